// File: rtl/iter_div_pkg.sv
// rtl/iter_div_pkg.sv - shared state encoding and special-result constants for the iterative divider
package iter_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Widest operand supported; modules slice these down to their own width.
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] ALL_ONES = '1;

  function automatic logic [MAX_W-1:0] most_neg(input int w);
    logic [MAX_W-1:0] v;
    v = '0;
    v[w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/iter_div_lca.sv
// rtl/iter_div_lca.sv - N-bit lookahead adder built from 4-bit carry-lookahead groups
module iter_div_lca #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int NG = N / 4;

  logic [NG:0] c;

  assign c[0] = cin;
  assign cout = c[NG];

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic [3:0] p;
    logic [3:0] g;
    logic [4:1] cc;
    logic       c0;

    assign p  = a[4*gi +: 4] ^ b[4*gi +: 4];
    assign g  = a[4*gi +: 4] & b[4*gi +: 4];
    assign c0 = c[gi];

    // All group carries come straight from the group inputs, not from each other.
    assign cc[1] = g[0] | (p[0] & c0);
    assign cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign cc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & c0);
    assign cc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | ((&p) & c0);

    assign sum[4*gi +: 4] = p ^ {cc[3:1], c0};
    assign c[gi+1]        = cc[4];
  end

endmodule

// File: rtl/iter_div.sv
// rtl/iter_div.sv - iterative restoring divider, signed/unsigned, one quotient bit per cycle
module iter_div
  import iter_div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         cancel,
  input  logic         signed_op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;
  localparam logic [N-1:0] Q_ONES   = ALL_ONES[N-1:0];
  localparam logic [N-1:0] MOST_NEG = N'(most_neg(N));

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           sop;
  logic [N-1:0]   dvd;
  logic [N-1:0]   dvs;
  logic [N-1:0]   acc;
  logic [N-1:0]   rem_q;
  logic [N-1:0]   dneg;
  logic           q_neg;
  logic           r_neg;

  logic [N-1:0]   abs_dvd;
  logic [N-1:0]   abs_dvs;
  logic [N:0]     prem;
  logic [N-1:0]   trial;
  logic           trial_c;
  logic           no_borrow;

  assign abs_dvd = (sop && dvd[N-1]) ? -dvd : dvd;
  assign abs_dvs = (sop && dvs[N-1]) ? -dvs : dvs;

  // Shifted partial remainder: the extra top bit stands in for the borrow.
  assign prem = {rem_q, acc[N-1]};

  iter_div_lca #(.N(N)) u_lca (
    .a    (prem[N-1:0]),
    .b    (dneg),
    .cin  (1'b0),
    .sum  (trial),
    .cout (trial_c)
  );

  assign no_borrow = prem[N] | trial_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      sop         <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      acc         <= '0;
      rem_q       <= '0;
      dneg        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
    end else if (cancel) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            sop   <= signed_op;
            dvd   <= dividend;
            dvs   <= divisor;
            state <= PREP;
            busy  <= 1'b1;
          end
        end

        PREP: begin
          if (dvs == '0) begin
            quotient    <= Q_ONES;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else if (sop && dvd == MOST_NEG && dvs == Q_ONES) begin
            quotient    <= dvd;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            acc   <= abs_dvd;
            rem_q <= '0;
            dneg  <= -abs_dvs;
            q_neg <= sop & (dvd[N-1] ^ dvs[N-1]);
            r_neg <= sop & dvd[N-1];
            cnt   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          // acc shifts dividend bits out the top and quotient bits in the bottom.
          acc   <= {acc[N-2:0], no_borrow};
          rem_q <= no_borrow ? trial : prem[N-1:0];
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= FIX;
        end

        FIX: begin
          quotient    <= q_neg ? -acc : acc;
          remainder   <= r_neg ? -rem_q : rem_q;
          div_by_zero <= 1'b0;
          state       <= DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// tb/tb_iter_div.sv - directed vector and sequence bench for iter_div
module tb_iter_div;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cancel;
  logic         signed_op;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  iter_div #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cancel      (cancel),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic         sop;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Leaves time at E0+1ns with start already dropped.
  task automatic launch(input logic s, input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    signed_op = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int lat, output bit busy_ok);
    lat     = -1;
    busy_ok = busy;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int  lat;
    bit  bok;
    bit  seen;
    logic [N-1:0] held_q;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,        32'd14,       32'd2,        1'b0, 34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    vecs[2]  = '{1'b0, 32'd5,         32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1};
    vecs[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,  32'h10,       32'h0FFFFFFF, 32'hF,        1'b0, 34};
    vecs[5]  = '{1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0, 34};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 34};
    vecs[8]  = '{1'b0, 32'd3,         32'd5,        32'd0,        32'd3,        1'b0, 34};
    vecs[9]  = '{1'b1, 32'h80000000,  32'd1,        32'h80000000, 32'd0,        1'b0, 34};
    vecs[10] = '{1'b0, 32'h80000000,  32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 34};
    vecs[11] = '{1'b1, 32'hFFFFFFFB,  32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1};
    vecs[12] = '{1'b0, 32'd0,         32'd9,        32'd0,        32'd0,        1'b0, 34};
    vecs[13] = '{1'b1, 32'h80000000,  32'd2,        32'hC0000000, 32'd0,        1'b0, 34};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_op = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", N'(busy), '0);
    check("reset_done", N'(done), '0);
    check("reset_q", quotient, '0);
    check("reset_r", remainder, '0);
    check("reset_dbz", N'(div_by_zero), '0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      launch(vecs[i].sop, vecs[i].a, vecs[i].b);
      wait_done(60, lat, bok);
      check_int($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_q", i), quotient, vecs[i].q);
      check($sformatf("v%0d_r", i), remainder, vecs[i].r);
      check($sformatf("v%0d_dbz", i), N'(div_by_zero), N'(vecs[i].z));
      check($sformatf("v%0d_busy", i), N'(bok), N'(1'b1));
    end

    // done is a single pulse and results hold afterwards
    @(posedge clk); #1;
    check("done_pulse_width", N'(done), '0);
    check("hold_q", quotient, 32'hC0000000);

    // start while busy is ignored
    launch(1'b0, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #1 dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(60, lat, bok);
    check_int("busy_start_seen_done", lat > 0 ? 1 : 0, 1);
    check("busy_start_q", quotient, 32'd14);
    check("busy_start_r", remainder, 32'd2);

    // start during the DONE cycle is accepted
    launch(1'b0, 32'd100, 32'd7);
    wait_done(60, lat, bok);
    signed_op = 1'b0; dividend = 32'hFFFFFFFF; divisor = 32'h10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("done_start_busy", N'(busy), N'(1'b1));
    check("done_start_done_low", N'(done), '0);
    wait_done(60, lat, bok);
    check_int("done_start_latency", lat, 34);
    check("done_start_q", quotient, 32'h0FFFFFFF);
    check("done_start_r", remainder, 32'hF);

    // cancel at E0+10 suppresses done and leaves results untouched
    held_q = quotient;
    launch(1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    check("cancel_busy", N'(busy), '0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("cancel_no_done", N'(seen), '0);
    check("cancel_q_held", quotient, held_q);
    launch(1'b0, 32'd9, 32'd3);
    wait_done(60, lat, bok);
    check_int("after_cancel_latency", lat, 34);
    check("after_cancel_q", quotient, 32'd3);
    check("after_cancel_r", remainder, 32'd0);

    // cancel beats a simultaneous start
    @(negedge clk);
    dividend = 32'd8; divisor = 32'd2; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1 start = 1'b0; cancel = 1'b0;
    check("cancel_over_start", N'(busy), '0);

    // reset mid-RUN clears everything
    launch(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("rst_run_busy", N'(busy), '0);
    check("rst_run_done", N'(done), '0);
    check("rst_run_q", quotient, '0);
    check("rst_run_r", remainder, '0);
    check("rst_run_dbz", N'(div_by_zero), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
